// File: rtl/isa_pkg.sv
// ISA field positions, opcode values and fetch FSM encoding shared by the
// fetch stage and its next-PC selector.
package isa_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int JTGT_W  = 11;
    localparam int IMM_W   = 5;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_J    = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_LW   = 5'b00100;
    localparam logic [4:0] OP_SW   = 5'b00101;
    localparam logic [4:0] OP_BEQ  = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_XORI = 5'b01011;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode/control.
// Handshakes: a memory transfer completes on a cycle with imem_req & imem_ready;
// a decode transfer completes on a cycle with instr_valid & instr_ready. Neither
// side may treat a lone ready as a transfer.
interface instr_fetch_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [4:0]         opcode;
    logic [PC_W-1:0]    pc_plus1;
    logic               jump;
    logic               branch;
    logic               alu_zero;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_plus1,
        input  imem_ready, imem_rdata, instr_ready, jump, branch, alu_zero
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_plus1,
        output imem_ready, imem_rdata, instr_ready, jump, branch, alu_zero
    );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC choice: jump target, taken branch, or fall-through.
// Jump has priority over branch; all arithmetic wraps modulo 2^PC_W.
module next_pc_sel
    import isa_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0]   i_pc_plus1,
    input  logic [JTGT_W-1:0] i_instr_low,
    input  logic              i_jump,
    input  logic              i_branch,
    input  logic              i_alu_zero,
    output logic [PC_W-1:0]   o_next_pc
);
    logic [PC_W-1:0] w_jump_tgt;
    logic [PC_W-1:0] w_imm_sext;
    logic [PC_W-1:0] w_br_tgt;

    // Jump keeps the upper region bits of the return address.
    assign w_jump_tgt = {i_pc_plus1[PC_W-1:JTGT_W], i_instr_low};
    assign w_imm_sext = {{(PC_W-IMM_W){i_instr_low[IMM_W-1]}}, i_instr_low[IMM_W-1:0]};
    assign w_br_tgt   = i_pc_plus1 + w_imm_sext;

    always_comb begin
        o_next_pc = i_pc_plus1;
        if (i_jump) begin
            o_next_pc = w_jump_tgt;
        end else if (i_branch && i_alu_zero) begin
            o_next_pc = w_br_tgt;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: fetches one instruction at pc, holds it for decode, and
// advances pc to the selected next address when decode consumes it.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus,
    output fetch_state_t  o_dbg_state
);
    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_pc_plus1;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    w_next_pc;
    logic               w_imem_req;
    logic               w_instr_valid;
    logic               w_fetch_done;
    logic               w_hold_done;

    next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
        .i_pc_plus1  (r_pc_plus1),
        .i_instr_low (r_instr[JTGT_W-1:0]),
        .i_jump      (bus.jump),
        .i_branch    (bus.branch),
        .i_alu_zero  (bus.alu_zero),
        .o_next_pc   (w_next_pc)
    );

    always_comb begin
        w_next_state  = r_state;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        w_fetch_done  = 1'b0;
        w_hold_done   = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req   = 1'b1;
                w_fetch_done = bus.imem_ready;
                if (bus.imem_ready) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_instr_valid = 1'b1;
                w_hold_done   = bus.instr_ready;
                if (bus.instr_ready) begin
                    w_next_state = FETCH;
                end
            end
            default: w_next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_pc_plus1 <= '0;
            r_instr    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fetch_done) begin
                r_instr    <= bus.imem_rdata;
                r_pc_plus1 <= r_pc + 1'b1;
            end
            if (w_hold_done) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // The request is masked during reset so memory never sees a fetch then.
    assign bus.imem_req    = w_imem_req & ~reset;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[OPC_MSB:OPC_LSB];
    assign bus.pc_plus1    = r_pc_plus1;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a PC-level reference model.
module tb_instr_fetch;
  import isa_pkg::*;

  localparam int PC_W = 16;
  localparam int INSTR_W = 16;

  logic clk;
  logic reset;
  fetch_state_t dbg_state;
  int n_checks;
  int n_errors;
  logic [15:0] m_pc;
  logic [PC_W-1:0] exp_q[$];

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: next PC from the architectural rules, plain integer arithmetic.
  function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] ins,
                                             input bit j, input bit b, input bit z);
    int p1;
    int off;
    p1 = (int'(pc) + 1) % 65536;
    if (j) return 16'((p1 / 2048) * 2048 + (int'(ins) % 2048));
    if (b && z) begin
      off = int'(ins) % 32;
      if (off >= 16) off = off - 32;
      return 16'((p1 + off + 65536) % 65536);
    end
    return 16'(p1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 16'($urandom);
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch = 1'b0;
    bus.alu_zero = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check_eq({tag, "_addr"}, 32'(bus.imem_addr), 32'h0000);
    check_eq({tag, "_instr"}, 32'(bus.instr), 32'd0);
    check_eq({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
    check_eq({tag, "_pcp1"}, 32'(bus.pc_plus1), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(FETCH));
  endtask

  // Entry and exit point: 1 time unit after a rising edge.
  task automatic fetch_one(input logic [15:0] rdata, input int waits, input int holds,
                           input bit j, input bit b, input bit z);
    int guard;
    logic [PC_W-1:0] exp_p1;
    guard = 0;
    while (!bus.imem_req && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("req_seen", 32'(bus.imem_req), 32'd1);
    check_eq("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
    check_eq("fetch_valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.instr_ready = 1'($urandom_range(0, 1));
      tick();
      check_eq("wait_req", 32'(bus.imem_req), 32'd1);
      check_eq("wait_addr", 32'(bus.imem_addr), 32'(m_pc));
      check_eq("wait_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.instr_ready = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = rdata;
    exp_q.push_back(m_pc + 16'd1);
    tick();
    idle_inputs();
    exp_p1 = exp_q.pop_front();
    check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("hold_instr", 32'(bus.instr), 32'(rdata));
    check_eq("hold_opcode", 32'(bus.opcode), 32'(rdata) >> 11);
    check_eq("hold_pcp1", 32'(bus.pc_plus1), 32'(exp_p1));
    check_eq("hold_req", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < holds; i++) begin
      bus.imem_ready = 1'($urandom_range(0, 1));
      bus.jump = 1'($urandom_range(0, 1));
      bus.branch = 1'($urandom_range(0, 1));
      bus.alu_zero = 1'($urandom_range(0, 1));
      tick();
      check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("stall_instr", 32'(bus.instr), 32'(rdata));
      check_eq("stall_opcode", 32'(bus.opcode), 32'(rdata) >> 11);
      check_eq("stall_req", 32'(bus.imem_req), 32'd0);
    end
    bus.imem_ready = 1'b0;
    bus.instr_ready = 1'b1;
    bus.jump = j;
    bus.branch = b;
    bus.alu_zero = z;
    tick();
    idle_inputs();
    m_pc = model_next(m_pc, rdata, j, b, z);
  endtask

  // Reset asserted between edges, either while waiting on memory or while holding.
  task automatic reset_mid(input bit in_hold);
    if (in_hold) begin
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 16'hFFFF;
      tick();
      bus.imem_ready = 1'b0;
      check_eq("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
    end else begin
      bus.imem_ready = 1'b0;
      tick();
      check_eq("pre_rst_req", 32'(bus.imem_req), 32'd1);
    end
    #2;
    reset = 1'b1;
    bus.imem_ready = 1'b1;
    bus.instr_ready = 1'b1;
    bus.jump = 1'b1;
    #1;
    check_reset_values(in_hold ? "rst_hold" : "rst_fetch");
    tick();
    check_reset_values(in_hold ? "rst_hold_edge" : "rst_fetch_edge");
    reset = 1'b0;
    idle_inputs();
    m_pc = 16'h0000;
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_pc = 16'h0000;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;

    // sequential run, then wait states and decode stalls
    for (int i = 0; i < 4; i++) fetch_one(16'($urandom), 0, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(16'h0001, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(16'h3A5C, 3, 2, 1'b0, 1'b0, 1'b0);
    // jumps into region 0 then across 0x0800
    fetch_one(16'h1010, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch_one(16'h13FF, 0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("jump_0x3ff", 32'(m_pc), 32'h03FF);
    fetch_one(16'h17FF, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch_one(16'h0000, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch_one(16'h300F, 0, 0, 1'b0, 1'b1, 1'b1);
    fetch_one(16'h13FF, 0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("jump_0xbff", 32'(m_pc), 32'h0BFF);
    fetch_one(16'h0000, 1, 1, 1'b0, 1'b0, 1'b0);
    reset_mid(1'b1);

    // beq taken / not taken / jump priority
    fetch_one(16'h1020, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch_one(16'h301C, 0, 0, 1'b0, 1'b1, 1'b1);
    check_eq("beq_taken", 32'(m_pc), 32'h001D);
    fetch_one(16'h1020, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch_one(16'h301C, 0, 0, 1'b0, 1'b1, 1'b0);
    check_eq("beq_not_taken", 32'(m_pc), 32'h0021);
    fetch_one(16'h1020, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch_one(16'h301C, 0, 0, 1'b1, 1'b1, 1'b1);
    check_eq("jump_priority", 32'(m_pc), 32'h001C);
    reset_mid(1'b0);

    // wrap below zero and above 0xFFFF
    fetch_one(16'h3010, 0, 0, 1'b0, 1'b1, 1'b1);
    check_eq("wrap_neg", 32'(m_pc), 32'hFFF1);
    fetch_one(16'h17FF, 0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("at_ffff", 32'(m_pc), 32'hFFFF);
    fetch_one(16'h0000, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_pos", 32'(m_pc), 32'h0000);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      fetch_one(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)));
    end
    fetch_one(16'($urandom), 0, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage directly upstream of the control decoder. Holds the PC and fetches one instruction per word address from an instruction memory over a req/ready handshake. Presents the instruction, its 5-bit opcode and PC+1 to decode/control over a valid/ready handshake. On consumption, selects the next PC from the same-cycle jump/branch/zero decisions.

Parameters:
PC_W, 16, PC width in words (word-addressed instruction memory)
INSTR_W, 16, instruction width; fields defined in isa_pkg
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_W  word address of fetch (= pc)
imem_ready  in  1  imem_rdata valid this cycle; ignored when imem_req=0
imem_rdata  in  INSTR_W  fetched instruction
instr_valid  out  1  instr/opcode/pc_plus1 valid for decode
instr_ready  in  1  decode consumes the current instruction this cycle
instr  out  INSTR_W  registered instruction
opcode  out  5  instr[15:11], feeds control decoder
pc_plus1  out  PC_W  address of held instruction + 1 (return address for jal)
jump  in  1  from control, qualified by instr_valid&instr_ready
branch  in  1  from control
alu_zero  in  1  ALU zero flag for current instruction

Behaviour:
- Interface decided: one clock; reset asynchronous, active-high; ports named clk and reset.
- Reset: pc=RESET_PC, state=FETCH, instr=0, opcode=0, pc_plus1=0, instr_valid=0. imem_req=0 while reset asserted, then 1 from the first cycle after deassertion.
- FSM with two states:
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0. If imem_ready: load instr<=imem_rdata, pc_plus1<=pc+1, then go to HOLD. Otherwise stay in FETCH (unbounded wait states allowed).
  - HOLD: imem_req=0, instr_valid=1, outputs stable. If instr_ready: pc<=next_pc, go to FETCH. Otherwise stay in HOLD.
- Latency: imem_ready in cycle N -> instr_valid=1 in N+1. Zero-wait throughput is 1 instruction per 2 cycles.
- next_pc, evaluated only on the HOLD handshake:
  - jump=1: {pc_plus1[PC_W-1:11], instr[10:0]}
  - else branch=1 and alu_zero=1: pc_plus1 + sext(instr[4:0]), offset range -16..+15
  - else: pc_plus1
- jump has priority over branch when both are 1.
- All PC arithmetic is modulo 2^PC_W. PC 0xFFFF+1 wraps to 0x0000, and negative offsets wrap below 0.
- jump/branch/alu_zero are don't-care when the handshake does not occur.
- instr_ready while instr_valid=0 is ignored.
- Reset asserted mid-FETCH or mid-HOLD: immediate return to reset values. Any in-flight imem response is dropped. No handshake completes in a cycle where reset=1.
- opcode is a pure slice of the instr register, so it is never combinationally derived from imem_rdata.

Decomposition:
- isa_pkg holds:
  - field positions: OPC_MSB=15, OPC_LSB=11, JTGT_W=11, IMM_W=5
  - opcode constants: OP_ADD..OP_XORI = 5'b00000..5'b01011 (OP_J=5'b00010, OP_JAL=5'b00011, OP_BEQ=5'b00110)
  - FSM state encoding: FETCH, HOLD
- One sub-module, next_pc_sel: combinational pc_plus1/instr/jump/branch/alu_zero -> next_pc. It is unit-testable on its own.
- The FSM and registers stay in instr_fetch.

Test Plan:
1. Reset release, imem_ready=1 always, instr_ready=1, no jump/branch -> imem_addr sequence 0,1,2,3 on every other cycle; pc_plus1 = 1,2,3,4.
2. imem_ready held low 3 cycles at addr 5 -> imem_req/imem_addr=5 held for all 4 cycles; instr_valid rises the cycle after imem_ready. Then instr_ready low 2 cycles -> instr/opcode stable, no new imem_req.
3. At pc=0x0010, instr=0x13FF (opcode 00010 j, target 0x3FF), jump=1 -> next imem_addr=0x03FF. At pc=0x0810 with the same instr -> 0x0BFF.
4. beq at pc=0x0020, imm=5'b11100 (-4): alu_zero=1 -> next addr 0x001D; alu_zero=0 -> 0x0021; jump=1 and branch=1 together -> jump target wins.
5. pc=0xFFFF, no redirect -> pc_plus1=0x0000 and next imem_addr=0x0000. Branch at pc=0x0000 with offset -16 -> 0xFFF1.
6. Assert reset asynchronously (between clock edges) during FETCH wait and during HOLD -> outputs hit reset values immediately. Stale imem_ready in the reset cycle is ignored; restart at RESET_PC.
